// File: rtl/audio_dac_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_dac_serializer
//  Description : Left-justified mono serializer for an audio DAC (BCLK, LRCK,
//                DATA). Optional underrun counter enabled by the macro
//                AUDIO_DAC_UNDERRUN_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_req,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underrun
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    ,
    output logic [7:0]            underrun_cnt
`endif
);

    localparam int c_DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(DATA_WIDTH);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic                  r_first;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_BIT_W-1:0]    r_bit;
    logic                  r_bclk;
    logic                  r_lrck;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_frame;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_full;
    logic                  r_underrun;

    logic                  w_div_wrap;
    logic                  w_fall;
    logic                  w_bit_wrap;
    logic                  w_frame_end;
    logic                  w_right_req;
    logic                  w_load;
    logic                  w_underrun;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_div_wrap  = (r_div == c_DIV_MAX);
    assign w_fall      = (r_state == c_RUN) && w_div_wrap && r_bclk;
    assign w_bit_wrap  = (r_bit == c_BIT_MAX);
    assign w_frame_end = w_fall && w_bit_wrap && r_lrck;
    // Right-slot request is for the next frame, so it is withheld once en drops
    assign w_right_req = w_fall && w_bit_wrap && !r_lrck && en;
    assign w_load      = ((r_state == c_RUN) && r_first) || (w_frame_end && en);
    assign w_underrun  = w_load && !sample_valid && !r_full;
    assign w_load_data = sample_valid ? sample_in : (r_full ? r_buf : '0);

    assign sample_req  = resetN && (((r_state == c_IDLE) && en) || w_right_req);
    assign AUD_BCLK    = r_bclk;
    assign AUD_DACLRCK = r_lrck;
    assign AUD_DACDAT  = r_shift[DATA_WIDTH-1];
    assign underrun    = r_underrun;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= c_IDLE;
            r_first    <= 1'b0;
            r_div      <= '0;
            r_bit      <= '0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b0;
            r_shift    <= '0;
            r_frame    <= '0;
            r_buf      <= '0;
            r_full     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun;

            // A sample arriving in the load cycle bypasses the buffer entirely
            if (w_load) begin
                r_full <= 1'b0;
            end else if (sample_valid) begin
                r_buf  <= sample_in;
                r_full <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_bclk  <= 1'b0;
                    r_lrck  <= 1'b0;
                    r_shift <= '0;
                    r_first <= 1'b0;
                    if (en) begin
                        r_state <= c_RUN;
                        r_first <= 1'b1;
                    end
                end
                c_RUN: begin
                    r_first <= 1'b0;
                    r_div   <= w_div_wrap ? '0 : r_div + 1'b1;
                    if (w_div_wrap) begin
                        r_bclk <= ~r_bclk;
                    end
                    if (w_load) begin
                        r_frame <= w_load_data;
                        r_shift <= w_load_data;
                    end
                    if (w_fall) begin
                        r_bit <= w_bit_wrap ? '0 : r_bit + 1'b1;
                        if (w_bit_wrap) begin
                            r_lrck <= ~r_lrck;
                            if (!r_lrck) begin
                                r_shift <= r_frame;
                            end else if (!en) begin
                                r_state <= c_IDLE;
                                r_shift <= '0;
                            end
                        end else begin
                            r_shift <= r_shift << 1;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_underrun_cnt <= 8'd0;
        end else if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_audio_dac_serializer
//  Description : Directed self-checking bench for audio_dac_serializer
//                (DATA_WIDTH=16, BCLK_DIV=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_dac_serializer;

    localparam int DW = 16;

    logic          clk        = 1'b0;
    logic          resetN     = 1'b0;
    logic          en         = 1'b0;
    logic          man_valid  = 1'b0;
    logic          resp_valid = 1'b0;
    logic          auto_resp  = 1'b0;
    logic [DW-1:0] man_data   = '0;
    logic [DW-1:0] resp_data  = 16'hA55A;
    logic          sample_valid;
    logic [DW-1:0] sample_in;
    logic          sample_req;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          underrun;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [7:0]    underrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;
    int n_unr    = 0;
    int resp_cnt = 0;

    assign sample_valid = man_valid | resp_valid;
    assign sample_in    = resp_valid ? resp_data : man_data;

    audio_dac_serializer #(.DATA_WIDTH(DW), .BCLK_DIV(4)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_req   (sample_req),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .underrun     (underrun)
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Sine-table stand-in: answers each sample_req three cycles later
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_valid = 1'b1;
        end
        if (auto_resp && sample_req && resp_cnt == 0) resp_cnt = 3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (sample_req) n_req++;
        if (underrun) n_unr++;
    endtask

    // Walk BCLK rising edges k0..k1 of a frame, checking bit, slot and period
    task automatic rx_rises(input string tag, input logic [DW-1:0] word,
                            input int k0, input int k1, output time t16);
        logic prev;
        logic found;
        t16 = 0;
        for (int k = k0; k <= k1; k++) begin
            prev  = AUD_BCLK;
            found = 1'b0;
            for (int i = 1; i <= 40 && !found; i++) begin
                tick();
                if (AUD_BCLK && !prev) begin
                    found = 1'b1;
                    chk($sformatf("%s dat[%0d]", tag, k), AUD_DACDAT, word[DW-1-(k%DW)]);
                    chk($sformatf("%s lrck[%0d]", tag, k), AUD_DACLRCK, k >= DW);
                    if (k != k0) chk($sformatf("%s bclk period[%0d]", tag, k), i, 8);
                    if (k == DW) t16 = $time;
                end
                prev = AUD_BCLK;
            end
            chk($sformatf("%s rise[%0d] seen", tag, k), found, 1);
        end
    endtask

    initial begin
        time t_a, t_b, t_dummy;
        int  req_snap, unr_snap, hi_cnt;
        logic found;

        // Reset: all outputs low, sample_req masked even with en high
        en = 1'b1;
        tick(); tick();
        chk("rst bclk", AUD_BCLK, 0);
        chk("rst lrck", AUD_DACLRCK, 0);
        chk("rst dat", AUD_DACDAT, 0);
        chk("rst underrun", underrun, 0);
        chk("rst sample_req", sample_req, 0);
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        chk("rst underrun_cnt", underrun_cnt, 0);
`endif
        en = 1'b0;
        tick();
        resetN = 1'b1;
        repeat (5) tick();
        chk("idle bclk", AUD_BCLK, 0);
        chk("idle sample_req", sample_req, 0);

        // Pre-fill the buffer, then run with the 3-cycle responder
        man_valid = 1'b1; man_data = 16'hA55A;
        tick();
        man_valid = 1'b0; auto_resp = 1'b1; en = 1'b1;
        #1 chk("start sample_req", sample_req, 1);
        req_snap = n_req;
        rx_rises("f1", 16'hA55A, 0, 31, t_a);
        rx_rises("f2", 16'hA55A, 0, 31, t_b);
        chk("lrck period ns", int'(t_b - t_a), 2560);
        chk("req per frame", n_req - req_snap, 2);

        // Drop en during left-slot bit 5: frame completes, then idle
        rx_rises("f3", 16'hA55A, 0, 5, t_dummy);
        en = 1'b0;
        req_snap = n_req;
        rx_rises("f3", 16'hA55A, 6, 31, t_dummy);
        repeat (10) tick();
        chk("stop bclk", AUD_BCLK, 0);
        chk("stop lrck", AUD_DACLRCK, 0);
        chk("stop dat", AUD_DACDAT, 0);
        hi_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (AUD_BCLK || AUD_DACLRCK || AUD_DACDAT) hi_cnt++;
        end
        chk("idle after stop activity", hi_cnt, 0);
        chk("no req after stop", n_req - req_snap, 0);
        chk("no underrun while fed", n_unr, 0);

        // Sample in the exact load cycle goes straight out, no underrun
        auto_resp = 1'b0;
        en = 1'b1;
        tick();
        man_valid = 1'b1; man_data = 16'h7FFF;
        tick();
        man_valid = 1'b0;
        chk("coincident no underrun", underrun, 0);
        chk("coincident msb", AUD_DACDAT, 0);
        unr_snap = n_unr;
        rx_rises("c7fff", 16'h7FFF, 0, 31, t_dummy);
        chk("coincident frame underruns", n_unr - unr_snap, 0);

        // Starved: zero data and one underrun per frame
        rx_rises("starve1", 16'h0000, 0, 31, t_dummy);
        chk("starve1 underruns", n_unr - unr_snap, 1);
        rx_rises("starve2", 16'h0000, 0, 31, t_dummy);
        rx_rises("starve3", 16'h0000, 0, 31, t_dummy);
        chk("starve3 underruns", n_unr - unr_snap, 3);
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        chk("underrun_cnt 3", underrun_cnt, 3);
        repeat (260 * 256) tick();
        chk("underrun_cnt saturated", underrun_cnt, 255);
`endif

        // Asynchronous reset in the middle of the right slot
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (AUD_DACLRCK) found = 1'b1;
        end
        chk("reach right slot", found, 1);
        repeat (30) tick();
        #2 resetN = 1'b0;
        #1;
        chk("async rst bclk", AUD_BCLK, 0);
        chk("async rst lrck", AUD_DACLRCK, 0);
        chk("async rst dat", AUD_DACDAT, 0);
        chk("async rst underrun", underrun, 0);
        chk("async rst sample_req", sample_req, 0);
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        chk("async rst underrun_cnt", underrun_cnt, 0);
`endif
        tick(); tick();
        resetN = 1'b1;
        #1 chk("post-rst first req", sample_req, 1);
        tick();
        chk("post-rst req one cycle", sample_req, 0);
        chk("post-rst lrck", AUD_DACLRCK, 0);
        rx_rises("post-rst", 16'h0000, 0, 3, t_dummy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001: Parameter DATA_WIDTH, default 16, sample width and bit-clocks per channel slot (legal 8..24).
REQ-002: Parameter BCLK_DIV, default 4, clk cycles per BCLK half-period (legal 2..255).
REQ-003: clk  input  1  system clock; all state updates on its rising edge.
REQ-004: resetN  input  1  asynchronous active-low reset.
REQ-005: en  input  1  run enable; high = transmit frames, low = stop at the next frame boundary.
REQ-006: sample_in  input  DATA_WIDTH  signed sample from the sine table.
REQ-007: sample_valid  input  1  one-cycle strobe; sample_in is captured in the cycle it is high.
REQ-008: sample_req  output  1  one-cycle pulse requesting the next sample; drives the address counter's enable.
REQ-009: AUD_BCLK  output  1  serial bit clock.
REQ-010: AUD_DACLRCK  output  1  channel select; 0 = left slot, 1 = right slot.
REQ-011: AUD_DACDAT  output  1  serial data, MSB first.
REQ-012: underrun  output  1  one-cycle pulse when a frame starts with no fresh sample.

Function
REQ-013: States are IDLE and RUN; IDLE->RUN when en=1 in IDLE; RUN->IDLE only at a frame boundary with en=0.
REQ-014: In IDLE: AUD_BCLK, AUD_DACLRCK and AUD_DACDAT SHALL be 0; the divider and bit index SHALL be held at 0.
REQ-015: Divider counts 0..BCLK_DIV-1; AUD_BCLK toggles in the cycle the count wraps, giving a BCLK period of 2*BCLK_DIV clk cycles.
REQ-016: Format is left-justified mono: the same sample is sent in both slots; the MSB is valid from the AUD_DACLRCK edge.
REQ-017: AUD_DACDAT and AUD_DACLRCK change only in the cycle AUD_BCLK goes 1->0, i.e. they are stable across every BCLK rising edge.
REQ-018: Bit index runs 0..DATA_WIDTH-1 per slot; at wrap AUD_DACLRCK toggles; a frame is 2*DATA_WIDTH BCLK periods.
REQ-019: Frame boundary is the BCLK falling edge where AUD_DACLRCK goes 1->0, plus the first cycle after IDLE->RUN; at it the shift register loads the buffered sample.
REQ-020: sample_req SHALL pulse for exactly one clk cycle at the BCLK falling edge that starts each right slot, and also in the IDLE->RUN cycle.
REQ-021: sample_valid writes a one-entry buffer and sets its full flag; a second sample_valid before the load overwrites the buffer (last wins).
REQ-022: At load with the full flag set: transmit the buffer and clear the flag.
REQ-023: At load with the full flag clear: transmit all zeros and pulse underrun for one cycle.
REQ-024: If sample_valid coincides with a load cycle, sample_in goes directly to the shift register, the flag stays clear, and no underrun is raised.
REQ-025: en falling mid-frame SHALL NOT truncate the frame; the frame completes and the block then enters IDLE; no sample_req is issued for the aborted next frame.

Reset
REQ-026: On resetN=0, immediately and independent of clk: state=IDLE, all outputs 0, buffer full flag clear, counters 0.
REQ-027: Reset mid-frame abandons the frame; the first frame after release starts only once en=1.

Configuration
REQ-028: Macro AUDIO_DAC_UNDERRUN_CNT_EN defined: add output underrun_cnt, 8 bits, counting underrun pulses, saturating at 255, cleared by reset only.
REQ-029: Macro AUDIO_DAC_UNDERRUN_CNT_EN undefined: no underrun_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-030: DATA_WIDTH=16, BCLK_DIV=4, en=1, respond to each sample_req with 0xA55A after 3 cycles -> each slot carries 1010010101011010 MSB first; BCLK period = 8 clk cycles; LRCK period = 256 clk cycles; underrun never pulses.
REQ-031: Never assert sample_valid -> all-zero data every frame, one underrun pulse per frame, and underrun_cnt saturates at 255 with the macro defined.
REQ-032: Assert sample_valid in the exact load cycle with 0x7FFF -> 0x7FFF is sent in that frame and no underrun pulse occurs.
REQ-033: Drop en at bit 5 of the left slot -> the frame completes through the right slot LSB, then all outputs go 0, with no further sample_req.
REQ-034: Assert resetN=0 mid-right-slot, between clk edges -> outputs go 0 asynchronously; after release with en=1, sample_req pulses in the first cycle.
